// File: rtl/display_pkg.sv
// Shared definitions for the binary-to-BCD converter and the seven-segment
// display stage that consumes its digits.
package display_pkg;

  localparam int WIDTH          = 16;
  localparam int BCD_DIGITS     = 5;
  localparam int OUT_DIGITS     = 4;
  localparam int MAX_VALUE      = 9999;
  localparam int ADD3_THRESHOLD = 5;

  // Digit code the display stage renders as an unlit digit.
  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_add3.sv
// One BCD column corrector for the double-dabble engine: a column holding
// 5..9 gets +3 so that the following left shift carries into the next decade.
module bcd_add3
  import display_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  localparam logic [3:0] THRESH = 4'(ADD3_THRESHOLD);

  // Values 5..9 map to 8..12, so the result always fits in four bits.
  always_comb begin
    dout = din;
    if (din >= THRESH) dout = din + 4'd3;
  end

endmodule

// File: rtl/bin16_to_bcd_seq.sv
// Sequential 16-bit binary to four-digit BCD converter (shift-add-3).
// A Start in IDLE captures Number; sixteen shift iterations later the digits
// load and Done pulses for one cycle. Values above MAX_VALUE blank all digits.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for Start; outputs hold the last result
// ST_SHIFT | one correct-and-shift iteration per clock, WIDTH clocks
// ST_LOAD  | copy BCD columns (or blanks) to the outputs, pulse Done
module bin16_to_bcd_seq
  import display_pkg::*;
#(
  parameter int WIDTH      = display_pkg::WIDTH,
  parameter int BCD_DIGITS = display_pkg::BCD_DIGITS,
  parameter int OUT_DIGITS = display_pkg::OUT_DIGITS,
  parameter int MAX_VALUE  = display_pkg::MAX_VALUE
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] Number,
  output logic             Busy,
  output logic             Done,
  output logic             Overflow,
  output logic [3:0]       Digit0,
  output logic [3:0]       Digit1,
  output logic [3:0]       Digit2,
  output logic [3:0]       Digit3
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int BCD_W = 4 * BCD_DIGITS;

  localparam logic [WIDTH-1:0] MAX_VAL_W = WIDTH'(MAX_VALUE);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] bcd_corr;
  logic [CNT_W-1:0] iter_q;
  logic             ovf_pending_q;
  logic [3:0]       digit_q [OUT_DIGITS];

  // Column correctors; the top column only ever feeds back into the engine.
  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (bcd_q[4*g +: 4]),
      .dout (bcd_corr[4*g +: 4])
    );
  end

  assign Digit0 = digit_q[0];
  assign Digit1 = digit_q[1];
  assign Digit2 = digit_q[2];
  assign Digit3 = digit_q[3];

  // Control FSM, shift engine and held output registers.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q       <= ST_IDLE;
      bin_q         <= '0;
      bcd_q         <= '0;
      iter_q        <= '0;
      ovf_pending_q <= 1'b0;
      Busy          <= 1'b0;
      Done          <= 1'b0;
      Overflow      <= 1'b0;
      for (int i = 0; i < OUT_DIGITS; i++) digit_q[i] <= 4'd0;
    end else begin
      // Done is a single-cycle strobe; only LOAD re-asserts it.
      Done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            bin_q         <= Number;
            bcd_q         <= '0;
            ovf_pending_q <= (Number > MAX_VAL_W);
            iter_q        <= '0;
            Busy          <= 1'b1;
            state_q       <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // Correct first, then shift the combined register left one bit.
          {bcd_q, bin_q} <= {bcd_corr, bin_q} << 1;
          iter_q         <= iter_q + CNT_W'(1);
          if (iter_q == LAST_ITER) state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          for (int i = 0; i < OUT_DIGITS; i++)
            digit_q[i] <= ovf_pending_q ? BLANK_CODE : bcd_q[4*i +: 4];
          Overflow <= ovf_pending_q;
          Done     <= 1'b1;
          Busy     <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: begin
          Busy    <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
